// File: rtl/sram_fpga_pipelined_if.sv
// Request/response bus for sram_fpga_pipelined. Per-port fields are flat vectors, lane p = port p.
interface sram_fpga_pipelined_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MASK_WIDTH = 16
);
  logic [NUM_PORTS-1:0]            rw_enable;
  logic [NUM_PORTS-1:0]            rw_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] rw_addr;
  logic [NUM_PORTS*MASK_WIDTH-1:0] rw_mask;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rw_dataIn;
  logic                            rw_ready;
  logic [NUM_PORTS-1:0]            rw_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rw_dataOut;

  modport master (
    output rw_enable, rw_write, rw_addr, rw_mask, rw_dataIn,
    input  rw_ready, rw_valid, rw_dataOut
  );

  modport slave (
    input  rw_enable, rw_write, rw_addr, rw_mask, rw_dataIn,
    output rw_ready, rw_valid, rw_dataOut
  );
endinterface

// File: rtl/sram_fpga_pipelined.sv
// Multi-port byte-masked FPGA block RAM with zero-fill sequencer after reset and 1/2-cycle read latency.
// Optional macro SRAM_FWD_EN: write-first forwarding on read/write collisions (default read-first).
module sram_fpga_pipelined #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned MASK_UNIT    = 8,
  parameter int unsigned MASK_WIDTH   = (DATA_WIDTH + MASK_UNIT - 1) / MASK_UNIT,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  sram_fpga_pipelined_if.slave rw_bus,
  output logic                 init_done
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MEM_W = MASK_WIDTH * MASK_UNIT;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_addr;
  logic             rw_ready_q;

  // Word width is padded to whole mask lanes so every lane write is a fixed-width slice.
  logic [MEM_W-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] p_addr  [NUM_PORTS];
  logic [IDX_W-1:0]      p_idx   [NUM_PORTS];
  logic [MASK_WIDTH-1:0] p_mask  [NUM_PORTS];
  logic [MEM_W-1:0]      p_wdata [NUM_PORTS];
  logic [MEM_W-1:0]      rd_word [NUM_PORTS];
  logic [NUM_PORTS-1:0]  in_range;
  logic [NUM_PORTS-1:0]  wr_ok;
  logic [NUM_PORTS-1:0]  rd_acc;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      p_addr[p]  = rw_bus.rw_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      p_idx[p]   = p_addr[p][IDX_W-1:0];
      p_mask[p]  = rw_bus.rw_mask[p*MASK_WIDTH +: MASK_WIDTH];
      p_wdata[p] = '0;
      p_wdata[p][DATA_WIDTH-1:0] = rw_bus.rw_dataIn[p*DATA_WIDTH +: DATA_WIDTH];
      in_range[p] = 32'(p_addr[p]) < DEPTH;
      wr_ok[p]  = rw_bus.rw_enable[p] && rw_ready_q && rw_bus.rw_write[p] && in_range[p];
      rd_acc[p] = rw_bus.rw_enable[p] && rw_ready_q && !rw_bus.rw_write[p];
    end
  end

  always_comb begin
    for (int unsigned rp = 0; rp < NUM_PORTS; rp++) begin
      rd_word[rp] = in_range[rp] ? mem[p_idx[rp]] : '0;
`ifdef SRAM_FWD_EN
      // Writers applied highest index first, so the lowest-index writer owns each lane.
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (in_range[rp] && wr_ok[NUM_PORTS-1-k] && p_idx[NUM_PORTS-1-k] == p_idx[rp]) begin
          for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (p_mask[NUM_PORTS-1-k][i])
              rd_word[rp][i*MASK_UNIT +: MASK_UNIT] = p_wdata[NUM_PORTS-1-k][i*MASK_UNIT +: MASK_UNIT];
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!rw_ready_q) begin
      mem[init_addr] <= '0;
    end else begin
      // Later non-blocking writes win, so iterating high-to-low gives the lowest port priority.
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (wr_ok[NUM_PORTS-1-k]) begin
          for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (p_mask[NUM_PORTS-1-k][i])
              mem[p_idx[NUM_PORTS-1-k]][i*MASK_UNIT +: MASK_UNIT] <=
                p_wdata[NUM_PORTS-1-k][i*MASK_UNIT +: MASK_UNIT];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_INIT;
      init_addr  <= '0;
      rw_ready_q <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      init_done <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_addr == IDX_W'(DEPTH - 1)) begin
            state      <= S_READY;
            rw_ready_q <= 1'b1;
            init_done  <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        S_READY: rw_ready_q <= 1'b1;
        default: begin
          state      <= S_INIT;
          init_addr  <= '0;
          rw_ready_q <= 1'b0;
        end
      endcase
    end
  end

  logic [NUM_PORTS-1:0]  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  out_valid;
  logic [DATA_WIDTH-1:0] out_data [NUM_PORTS];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) s1_data[p] <= '0;
    end else begin
      s1_valid <= rd_acc;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (rd_acc[p]) s1_data[p] <= rd_word[p][DATA_WIDTH-1:0];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    always_ff @(posedge clock) begin
      if (reset) begin
        out_valid <= '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) out_data[p] <= '0;
      end else begin
        out_valid <= s1_valid;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (s1_valid[p]) out_data[p] <= s1_data[p];
        end
      end
    end
  end else begin : g_no_out_reg
    always_comb begin
      out_valid = s1_valid;
      for (int unsigned p = 0; p < NUM_PORTS; p++) out_data[p] = s1_data[p];
    end
  end

  assign rw_bus.rw_ready = rw_ready_q;
  assign rw_bus.rw_valid = out_valid;

  always_comb begin
    rw_bus.rw_dataOut = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      rw_bus.rw_dataOut[p*DATA_WIDTH +: DATA_WIDTH] = out_data[p];
  end
endmodule

// File: tb/tb_sram_fpga_pipelined.sv
// Self-checking bench for sram_fpga_pipelined: directed table, multi-cycle sequences, random traffic vs model.
module tb_sram_fpga_pipelined;
  localparam int unsigned DEPTH = 16, DW = 32, MU = 8, MW = 4, AW = 5, P = 2, RL = 2;
`ifdef SRAM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic init_done;
  always #5 clock = ~clock;

  sram_fpga_pipelined_if #(.NUM_PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  sram_fpga_pipelined #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .MASK_UNIT(MU), .ADDR_WIDTH(AW),
    .NUM_PORTS(P), .READ_LATENCY(RL)
  ) dut (
    .clock(clock), .reset(reset), .rw_bus(bus), .init_done(init_done)
  );

  logic [P-1:0]  en = '0, wr = '0;
  logic [AW-1:0] ad [P];
  logic [MW-1:0] mk [P];
  logic [DW-1:0] dn [P];

  assign bus.rw_enable = en;
  assign bus.rw_write  = wr;
  assign bus.rw_addr   = {ad[1], ad[0]};
  assign bus.rw_mask   = {mk[1], mk[0]};
  assign bus.rw_dataIn = {dn[1], dn[0]};

  // Reference model: word array, ready/init tracking, queue of responses due at a given edge.
  typedef struct { int due; int port; logic [DW-1:0] data; } resp_t;
  resp_t         rq[$];
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_out [P];
  bit            m_ready = 1'b0, m_done = 1'b0;
  int            init_left = DEPTH;
  int            edge_n = 0, n_checks = 0, n_fail = 0, done_cnt = 0;
  int            vcount [P];

  typedef struct {
    logic [P-1:0] en, wr; logic [AW-1:0] a0, a1; logic [MW-1:0] m0, m1;
    logic [DW-1:0] d0, d1; logic [P-1:0] ev; logic [DW-1:0] e0, e1;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] nxt [DEPTH];
    bit            claimed [DEPTH][MW];
    logic [DW-1:0] rd;
    int            a;
    m_done = 1'b0;
    if (reset) begin
      m_ready = 1'b0; init_left = DEPTH; rq.delete();
      for (int p = 0; p < P; p++) m_out[p] = '0;
    end else if (!m_ready) begin
      m_mem[DEPTH - init_left] = '0;
      init_left--;
      if (init_left == 0) begin m_ready = 1'b1; m_done = 1'b1; end
    end else begin
      nxt = m_mem;
      foreach (claimed[i, j]) claimed[i][j] = 1'b0;
      for (int p = 0; p < P; p++) begin
        a = int'(ad[p]);
        if (en[p] && wr[p] && a < DEPTH)
          for (int l = 0; l < MW; l++)
            if (mk[p][l] && !claimed[a][l]) begin
              nxt[a][l*MU +: MU] = dn[p][l*MU +: MU];
              claimed[a][l] = 1'b1;
            end
      end
      for (int p = 0; p < P; p++) begin
        a = int'(ad[p]);
        if (en[p] && !wr[p]) begin
          if (a >= DEPTH) rd = '0;
          else rd = FWD ? nxt[a] : m_mem[a];
          rq.push_back('{edge_n + RL - 1, p, rd});
        end
      end
      m_mem = nxt;
    end
  endtask

  task automatic check_outputs();
    bit ev [P];
    for (int p = 0; p < P; p++) ev[p] = 1'b0;
    while (rq.size() > 0 && rq[0].due <= edge_n) begin
      ev[rq[0].port]    = 1'b1;
      m_out[rq[0].port] = rq[0].data;
      void'(rq.pop_front());
    end
    chk("ready", 64'(bus.rw_ready), 64'(m_ready));
    chk("init_done", 64'(init_done), 64'(m_done));
    if (init_done) done_cnt++;
    for (int p = 0; p < P; p++) begin
      chk($sformatf("valid%0d", p), 64'(bus.rw_valid[p]), 64'(ev[p]));
      chk($sformatf("dataOut%0d", p), 64'(bus.rw_dataOut[p*DW +: DW]), 64'(m_out[p]));
      if (bus.rw_valid[p]) vcount[p]++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    edge_n++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    en = '0; wr = '0;
    for (int p = 0; p < P; p++) begin ad[p] = '0; mk[p] = '0; dn[p] = '0; end
  endtask

  task automatic wait_init(input bool_reads);
    int cnt = 0;
    while (!bus.rw_ready && cnt < 100) begin
      if (bool_reads) begin
        en = '1; wr = '0; ad[0] = AW'($urandom_range(0, DEPTH - 1)); ad[1] = AW'($urandom_range(0, DEPTH - 1));
      end
      step();
      cnt++;
    end
    idle();
    chk("init_cycles", 64'(cnt), 64'(DEPTH));
  endtask

  initial begin
    idle();
    for (int p = 0; p < P; p++) vcount[p] = 0;
    tbl[0]  = '{2'b01, 2'b01, 5'd5,  5'd0,  4'h1,    4'h0,    32'h1234AABB, 32'h0,        2'b00, 32'h0,        32'h0};
    tbl[1]  = '{2'b01, 2'b00, 5'd5,  5'd0,  4'h0,    4'h0,    32'h0,        32'h0,        2'b01, 32'h000000BB, 32'h0};
    tbl[2]  = '{2'b11, 2'b11, 5'd3,  5'd3,  4'hF,    4'hF,    32'h11111111, 32'h22222222, 2'b00, 32'h0,        32'h0};
    tbl[3]  = '{2'b10, 2'b00, 5'd0,  5'd3,  4'h0,    4'h0,    32'h0,        32'h0,        2'b10, 32'h0,        32'h11111111};
    tbl[4]  = '{2'b11, 2'b11, 5'd3,  5'd3,  4'b0101, 4'b0011, 32'h33333333, 32'h44444444, 2'b00, 32'h0,        32'h0};
    tbl[5]  = '{2'b01, 2'b00, 5'd3,  5'd0,  4'h0,    4'h0,    32'h0,        32'h0,        2'b01, 32'h11334433, 32'h0};
    tbl[6]  = '{2'b11, 2'b01, 5'd7,  5'd7,  4'hF,    4'h0,    32'hFFFFFFFF, 32'h0,        2'b10, 32'h0,        FWD ? 32'hFFFFFFFF : 32'h0};
    tbl[7]  = '{2'b01, 2'b00, 5'd7,  5'd0,  4'h0,    4'h0,    32'h0,        32'h0,        2'b01, 32'hFFFFFFFF, 32'h0};
    tbl[8]  = '{2'b11, 2'b01, 5'd20, 5'd20, 4'hF,    4'h0,    32'hDEADBEEF, 32'h0,        2'b10, 32'h0,        32'h0};
    tbl[9]  = '{2'b01, 2'b00, 5'd4,  5'd0,  4'h0,    4'h0,    32'h0,        32'h0,        2'b01, 32'h0,        32'h0};
    tbl[10] = '{2'b11, 2'b01, 5'd9,  5'd9,  4'h0,    4'h0,    32'hCAFEF00D, 32'h0,        2'b10, 32'h0,        32'h0};
    tbl[11] = '{2'b01, 2'b00, 5'd9,  5'd0,  4'h0,    4'h0,    32'h0,        32'h0,        2'b01, 32'h0,        32'h0};
    tbl[12] = '{2'b11, 2'b00, 5'd5,  5'd3,  4'h0,    4'h0,    32'h0,        32'h0,        2'b11, 32'h000000BB, 32'h11334433};
    tbl[13] = '{2'b11, 2'b01, 5'd15, 5'd0,  4'b1000, 4'h0,    32'hA5A5A5A5, 32'h0,        2'b10, 32'h0,        32'h0};
    tbl[14] = '{2'b10, 2'b00, 5'd0,  5'd15, 4'h0,    4'h0,    32'h0,        32'h0,        2'b10, 32'h0,        32'hA5000000};

    // Reset and zero-fill, then read every address on both ports.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    done_cnt = 0;
    wait_init(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      en = '1; wr = '0; ad[0] = AW'(i); ad[1] = AW'(DEPTH - 1 - i);
      step();
    end
    idle();
    repeat (RL) step();
    chk("init_done_pulses", 64'(done_cnt), 64'd1);

    // Directed table: one request vector, then wait out the read latency and check.
    foreach (tbl[i]) begin
      en = tbl[i].en; wr = tbl[i].wr;
      ad[0] = tbl[i].a0; ad[1] = tbl[i].a1; mk[0] = tbl[i].m0; mk[1] = tbl[i].m1;
      dn[0] = tbl[i].d0; dn[1] = tbl[i].d1;
      step();
      idle();
      repeat (RL - 1) step();
      chk($sformatf("tbl%0d_valid", i), 64'(bus.rw_valid), 64'(tbl[i].ev));
      if (tbl[i].ev[0]) chk($sformatf("tbl%0d_data0", i), 64'(bus.rw_dataOut[DW-1:0]), 64'(tbl[i].e0));
      if (tbl[i].ev[1]) chk($sformatf("tbl%0d_data1", i), 64'(bus.rw_dataOut[2*DW-1:DW]), 64'(tbl[i].e1));
    end

    // Back-to-back reads on all ports.
    for (int p = 0; p < P; p++) vcount[p] = 0;
    for (int c = 0; c < 100; c++) begin
      en = '1; wr = '0;
      for (int p = 0; p < P; p++) ad[p] = AW'($urandom_range(0, DEPTH + 3));
      step();
    end
    idle();
    repeat (RL) step();
    for (int p = 0; p < P; p++) chk($sformatf("b2b_count%0d", p), 64'(vcount[p]), 64'd100);

    // Random mixed traffic with frequent same-address collisions.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < P; p++) begin
        en[p] = 1'($urandom_range(0, 3) != 0);
        wr[p] = 1'($urandom_range(0, 1));
        ad[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH + 3));
        mk[p] = MW'($urandom);
        dn[p] = DW'($urandom);
      end
      step();
    end
    idle();
    repeat (RL) step();

    // Reset with reads in flight: responses dropped, outputs cleared, contents re-zeroed.
    en = 2'b01; wr = 2'b01; ad[0] = 5'd1; mk[0] = 4'hF; dn[0] = 32'h5A5A1234;
    step();
    wr = 2'b00;
    step();
    idle();
    repeat (RL) step();
    chk("pre_reset_data", 64'(bus.rw_dataOut[DW-1:0]), 64'h5A5A1234);
    en = 2'b11; wr = 2'b00; ad[0] = 5'd1; ad[1] = 5'd1;
    step();
    reset = 1'b1;
    step();
    chk("rst_valid", 64'(bus.rw_valid), 64'd0);
    chk("rst_data", 64'(bus.rw_dataOut), 64'd0);
    reset = 1'b0;
    wait_init(1'b1);
    en = 2'b01; wr = 2'b00; ad[0] = 5'd1;
    step();
    idle();
    repeat (RL - 1) step();
    chk("reinit_valid", 64'(bus.rw_valid[0]), 64'd1);
    chk("reinit_data", 64'(bus.rw_dataOut[DW-1:0]), 64'd0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
